// File: rtl/stage_memory_pipelined.sv
// Multi-cycle MEM stage: byte-addressable data memory with fixed access latency, MIPS lane logic
// and a MEM/WB output register. Optional macro MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses.
module stage_memory_pipelined #(
    parameter int ADDR_WIDTH  = 8,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_ALU_res,
    input  logic [31:0] i_rt_reg,
    input  logic [4:0]  i_addr_reg_dst,
    input  logic [31:0] i_pc_to_reg,
    input  logic        is_write_pc,
    input  logic        is_select_addr_reg,
    input  logic        is_RegWrite,
    input  logic        is_MemtoReg,
    input  logic        is_MemWrite,
    input  logic        is_MemRead,
    input  logic [2:0]  is_load_store_type,
    output logic [31:0] o_output_mem,
    output logic [31:0] o_ALU_res,
    output logic [4:0]  o_addr_reg_dst,
    output logic [31:0] o_pc_to_reg,
    output logic        os_write_pc,
    output logic        os_select_addr_reg,
    output logic        os_RegWrite,
    output logic        os_MemtoReg,
    output logic        o_stall,
    output logic        o_misaligned
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic        w_load_instr;
    logic        w_load_bubble;

    logic [31:0] r_mem [0:(2**ADDR_WIDTH)-1];

    logic                  w_req;
    logic                  w_is_load;
    logic                  w_commit;
    logic                  w_byte;
    logic                  w_half;
    logic                  w_unsigned;
    logic                  w_misaligned;
    logic [ADDR_WIDTH-1:0] w_word_addr;
    logic [1:0]            w_lane;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic [31:0]           w_rdata;
    logic [7:0]            w_byte_val;
    logic [15:0]           w_half_val;
    logic [31:0]           w_load_val;
    logic                  w_unused_addr_bits;

    // Both request bits high is treated as a write, so a load needs MemWrite low.
    assign w_req       = is_MemWrite | is_MemRead;
    assign w_is_load   = is_MemRead & ~is_MemWrite;
    assign w_commit    = (r_state == BUSY) && (r_cnt == 4'd0);
    assign w_byte      = (is_load_store_type[1:0] == 2'b00);
    assign w_half      = (is_load_store_type[1:0] == 2'b01);
    assign w_unsigned  = is_load_store_type[2];
    assign w_word_addr = i_ALU_res[ADDR_WIDTH+1:2];
    assign w_lane      = i_ALU_res[1:0];
    assign w_unused_addr_bits = ^i_ALU_res[31:ADDR_WIDTH+2];

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misaligned = w_req & ((w_half & w_lane[0]) | (~w_byte & ~w_half & (w_lane != 2'b00)));
`else
    assign w_misaligned = 1'b0;
`endif

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = i_rt_reg;
        if (w_byte) begin
            w_be    = 4'b0001 << w_lane;
            w_wdata = {4{i_rt_reg[7:0]}};
        end else if (w_half) begin
            w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{i_rt_reg[15:0]}};
        end
        if (w_misaligned) begin
            w_be = 4'b0000;
        end
    end

    // A reset edge that coincides with the commit edge abandons the write.
    always_ff @(posedge clk) begin
        if (i_rst_n && w_commit && is_MemWrite) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_word_addr][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    assign w_rdata    = r_mem[w_word_addr];
    assign w_byte_val = 8'(w_rdata >> {w_lane, 3'b000});
    assign w_half_val = w_lane[1] ? w_rdata[31:16] : w_rdata[15:0];

    always_comb begin
        w_load_val = w_rdata;
        if (w_byte) begin
            w_load_val = w_unsigned ? {24'b0, w_byte_val} : {{24{w_byte_val[7]}}, w_byte_val};
        end else if (w_half) begin
            w_load_val = w_unsigned ? {16'b0, w_half_val} : {{16{w_half_val[15]}}, w_half_val};
        end
        if (w_misaligned || !w_is_load) begin
            w_load_val = 32'b0;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        o_stall       = 1'b0;
        w_load_instr  = 1'b0;
        w_load_bubble = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    o_stall       = 1'b1;
                    w_state_next  = BUSY;
                    w_cnt_next    = 4'(MEM_LATENCY - 1);
                    w_load_bubble = 1'b1;
                end else begin
                    w_load_instr = 1'b1;
                end
            end
            BUSY: begin
                if (r_cnt != 4'd0) begin
                    o_stall       = 1'b1;
                    w_cnt_next    = r_cnt - 4'd1;
                    w_load_bubble = 1'b1;
                end else begin
                    w_state_next = IDLE;
                    w_load_instr = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_state            <= IDLE;
            r_cnt              <= 4'd0;
            o_output_mem       <= 32'b0;
            o_ALU_res          <= 32'b0;
            o_addr_reg_dst     <= 5'b0;
            o_pc_to_reg        <= 32'b0;
            os_write_pc        <= 1'b0;
            os_select_addr_reg <= 1'b0;
            os_RegWrite        <= 1'b0;
            os_MemtoReg        <= 1'b0;
            o_misaligned       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_load_instr) begin
                o_output_mem       <= w_load_val;
                o_ALU_res          <= i_ALU_res;
                o_addr_reg_dst     <= i_addr_reg_dst;
                o_pc_to_reg        <= i_pc_to_reg;
                os_write_pc        <= is_write_pc;
                os_select_addr_reg <= is_select_addr_reg;
                os_RegWrite        <= is_RegWrite & ~(w_is_load & w_misaligned);
                os_MemtoReg        <= is_MemtoReg;
                o_misaligned       <= w_misaligned;
            end else if (w_load_bubble) begin
                o_output_mem       <= 32'b0;
                o_ALU_res          <= 32'b0;
                o_addr_reg_dst     <= 5'b0;
                o_pc_to_reg        <= 32'b0;
                os_write_pc        <= 1'b0;
                os_select_addr_reg <= 1'b0;
                os_RegWrite        <= 1'b0;
                os_MemtoReg        <= 1'b0;
                o_misaligned       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stage_memory_pipelined.sv
// Directed bench for stage_memory_pipelined: byte-array memory model, per-cycle compare process
// and literal pins on key results. Follows MEM_MISALIGN_TRAP_EN the same way as the design.
module tb_stage_memory_pipelined;

  localparam int AW     = 8;
  localparam int LAT    = 2;
  localparam int NBYTES = 1 << (AW + 2);

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic [31:0] i_ALU_res, i_rt_reg, i_pc_to_reg;
  logic [4:0]  i_addr_reg_dst;
  logic        is_write_pc, is_select_addr_reg, is_RegWrite, is_MemtoReg;
  logic        is_MemWrite, is_MemRead;
  logic [2:0]  is_load_store_type;
  logic [31:0] o_output_mem, o_ALU_res, o_pc_to_reg;
  logic [4:0]  o_addr_reg_dst;
  logic        os_write_pc, os_select_addr_reg, os_RegWrite, os_MemtoReg;
  logic        o_stall, o_misaligned;

  stage_memory_pipelined #(.ADDR_WIDTH(AW), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .i_rst_n(i_rst_n),
    .i_ALU_res(i_ALU_res), .i_rt_reg(i_rt_reg), .i_addr_reg_dst(i_addr_reg_dst),
    .i_pc_to_reg(i_pc_to_reg), .is_write_pc(is_write_pc), .is_select_addr_reg(is_select_addr_reg),
    .is_RegWrite(is_RegWrite), .is_MemtoReg(is_MemtoReg), .is_MemWrite(is_MemWrite),
    .is_MemRead(is_MemRead), .is_load_store_type(is_load_store_type),
    .o_output_mem(o_output_mem), .o_ALU_res(o_ALU_res), .o_addr_reg_dst(o_addr_reg_dst),
    .o_pc_to_reg(o_pc_to_reg), .os_write_pc(os_write_pc), .os_select_addr_reg(os_select_addr_reg),
    .os_RegWrite(os_RegWrite), .os_MemtoReg(os_MemtoReg), .o_stall(o_stall),
    .o_misaligned(o_misaligned)
  );

  // clock / reset
  always #5 clk = ~clk;

  // model state
  logic [7:0]  mm [0:NBYTES-1];
  logic        exp_stall, exp_bubble;
  logic [31:0] exp_mem, exp_alu, exp_pc;
  logic [4:0]  exp_dst;
  logic        exp_wpc, exp_sel, exp_rw, exp_m2r, exp_mis;
  bit          chk_en = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int acc_size(input logic [2:0] t);
    case (t)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic bit is_mis(input logic [31:0] a, input logic [2:0] t);
`ifdef MEM_MISALIGN_TRAP_EN
    return (int'(a % 4) % acc_size(t)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int base_of(input logic [31:0] a, input logic [2:0] t);
    int sz = acc_size(t);
    return (int'(a % NBYTES) / sz) * sz;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] t);
    int sz = acc_size(t);
    int base = base_of(a, t);
    logic [31:0] v = 32'b0;
    for (int i = 0; i < sz; i++) v = v | (32'(mm[base + i]) << (8 * i));
    if (!t[2] && sz < 4 && v[8 * sz - 1]) v = v | (32'hFFFF_FFFF << (8 * sz));
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [2:0] t, input logic [31:0] d);
    int sz = acc_size(t);
    int base = base_of(a, t);
    for (int i = 0; i < sz; i++) mm[base + i] = 8'(d >> (8 * i));
  endtask

  // compare process: every falling edge once reset has been sampled
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("o_stall", 32'(o_stall), 32'(exp_stall));
      cmp("os_RegWrite", 32'(os_RegWrite), 32'(exp_rw));
      cmp("os_write_pc", 32'(os_write_pc), 32'(exp_wpc));
      cmp("os_MemtoReg", 32'(os_MemtoReg), 32'(exp_m2r));
      cmp("o_misaligned", 32'(o_misaligned), 32'(exp_mis));
      if (!exp_bubble) begin
        cmp("o_output_mem", o_output_mem, exp_mem);
        cmp("o_ALU_res", o_ALU_res, exp_alu);
        cmp("o_addr_reg_dst", 32'(o_addr_reg_dst), 32'(exp_dst));
        cmp("o_pc_to_reg", o_pc_to_reg, exp_pc);
        cmp("os_select_addr_reg", 32'(os_select_addr_reg), 32'(exp_sel));
      end
    end
  end

  // driver tasks
  task automatic drive(input logic [31:0] alu, rt, pc, input logic [4:0] dst,
                       input logic wpc, sel, rw, m2r, mw, mr, input logic [2:0] typ);
    i_ALU_res = alu; i_rt_reg = rt; i_pc_to_reg = pc; i_addr_reg_dst = dst;
    is_write_pc = wpc; is_select_addr_reg = sel; is_RegWrite = rw; is_MemtoReg = m2r;
    is_MemWrite = mw; is_MemRead = mr; is_load_store_type = typ;
  endtask

  task automatic set_bubble();
    exp_bubble = 1'b1; exp_rw = 1'b0; exp_wpc = 1'b0; exp_m2r = 1'b0; exp_mis = 1'b0;
  endtask

  task automatic set_zero();
    exp_bubble = 1'b0; exp_mem = 32'b0; exp_alu = 32'b0; exp_pc = 32'b0; exp_dst = 5'b0;
    exp_wpc = 1'b0; exp_sel = 1'b0; exp_rw = 1'b0; exp_m2r = 1'b0; exp_mis = 1'b0;
    exp_stall = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the instruction reaches MEM/WB.
  task automatic exec(input logic [31:0] alu, rt, pc, input logic [4:0] dst,
                      input logic wpc, sel, rw, m2r, mw, mr, input logic [2:0] typ);
    logic mem_op, load, mis;
    mem_op = mw | mr;
    load   = mr & ~mw;
    drive(alu, rt, pc, dst, wpc, sel, rw, m2r, mw, mr, typ);
    exp_stall = mem_op;
    if (mem_op) begin
      for (int k = 1; k <= LAT; k++) begin
        @(posedge clk); #1;
        set_bubble();
        exp_stall = (k < LAT);
      end
    end
    @(posedge clk); #1;
    mis = mem_op && is_mis(alu, typ);
    exp_bubble = 1'b0; exp_alu = alu; exp_dst = dst; exp_pc = pc;
    exp_wpc = wpc; exp_sel = sel; exp_m2r = m2r; exp_mis = mis;
    exp_rw  = rw & ~(load & mis);
    exp_mem = (load && !mis) ? model_load(alu, typ) : 32'b0;
    if (mw && !mis) model_store(alu, typ, rt);
    exp_stall = mem_op;
  endtask

  task automatic st(input logic [31:0] a, input logic [2:0] t, input logic [31:0] d);
    exec(a, d, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, t);
  endtask

  task automatic ld(input logic [31:0] a, input logic [2:0] t, input logic [4:0] dst);
    exec(a, 32'h0, 32'h0, dst, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, t);
  endtask

  task automatic nop();
    exec(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
  endtask

  // SW whose commit edge is a reset edge: the write must be abandoned.
  task automatic sw_with_reset(input logic [31:0] a, input logic [31:0] d);
    drive(a, d, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b011);
    exp_stall = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk); #1;
      set_bubble();
      exp_stall = (k < LAT);
      if (k == LAT) i_rst_n = 1'b0;
    end
    @(posedge clk); #1;
    set_zero();
    i_rst_n = 1'b1;
    drive(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
  endtask

  initial begin
    set_zero();
    i_rst_n = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 i_rst_n = 1'b1;
    cmp("rst_output_mem", o_output_mem, 32'h0);
    cmp("rst_regwrite", 32'(os_RegWrite), 32'h0);
    cmp("rst_stall", 32'(o_stall), 32'h0);

    // word round trip and address wrap
    st(32'h10, 3'b011, 32'hDEAD_BEEF);
    ld(32'h10, 3'b011, 5'd5);
    cmp("lw_word", o_output_mem, 32'hDEAD_BEEF);
    cmp("lw_regwrite", 32'(os_RegWrite), 32'h1);
    ld(32'h410, 3'b011, 5'd6);
    cmp("lw_wrap", o_output_mem, 32'hDEAD_BEEF);

    // byte / half extension
    st(32'h20, 3'b011, 32'h80FF_7F01);
    ld(32'h23, 3'b000, 5'd1);
    cmp("lb_sign", o_output_mem, 32'hFFFF_FF80);
    ld(32'h23, 3'b100, 5'd2);
    cmp("lbu_zero", o_output_mem, 32'h0000_0080);
    ld(32'h22, 3'b001, 5'd3);
    cmp("lh_sign", o_output_mem, 32'hFFFF_80FF);
    ld(32'h20, 3'b101, 5'd4);
    cmp("lhu_zero", o_output_mem, 32'h0000_7F01);
    ld(32'h21, 3'b000, 5'd4);
    cmp("lb_lane1", o_output_mem, 32'h0000_007F);

    // partial stores
    st(32'h20, 3'b011, 32'h0);
    st(32'h21, 3'b000, 32'h1234_56AB);
    ld(32'h20, 3'b011, 5'd7);
    cmp("sb_partial", o_output_mem, 32'h0000_AB00);
    st(32'h22, 3'b001, 32'hCAFE_BEEF);
    ld(32'h20, 3'b011, 5'd8);
    cmp("sh_partial", o_output_mem, 32'hBEEF_AB00);

    // non-memory instruction with misaligned-looking ALU result
    exec(32'h1233, 32'h9999, 32'h400, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b011);
    cmp("alu_pc_link", o_pc_to_reg, 32'h400);
    cmp("alu_no_stall_mis", 32'(o_misaligned), 32'h0);

    // misaligned word store and half load
    st(32'h22, 3'b011, 32'h1111_2222);
`ifdef MEM_MISALIGN_TRAP_EN
    cmp("sw_mis_flag", 32'(o_misaligned), 32'h1);
`endif
    ld(32'h20, 3'b011, 5'd10);
`ifdef MEM_MISALIGN_TRAP_EN
    cmp("sw_mis_unchanged", o_output_mem, 32'hBEEF_AB00);
`else
    cmp("sw_mis_masked", o_output_mem, 32'h1111_2222);
`endif
    ld(32'h21, 3'b001, 5'd11);

    // both request bits high behaves as a write
    exec(32'h30, 32'hA5A5_5A5A, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b011);
    ld(32'h30, 3'b011, 5'd12);
    cmp("both_high_write", o_output_mem, 32'hA5A5_5A5A);

    // reset during an access
    st(32'h40, 3'b011, 32'h1122_3344);
    sw_with_reset(32'h40, 32'h5566_7788);
    cmp("rst_mid_regwrite", 32'(os_RegWrite), 32'h0);
    ld(32'h40, 3'b011, 5'd13);
    cmp("rst_mid_old_value", o_output_mem, 32'h1122_3344);

    nop();
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
